// File: rtl/frame_sched_pkg.sv
// Shared types and default timing constants for the frame scheduler.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitData = 3'd1,
    StStart    = 3'd2,
    StActive   = 3'd3,
    StLatch    = 3'd4
  } state_e;

  localparam int unsigned FrameWordsDef   = 4248;
  localparam int unsigned LatchCyclesDef  = 6000;
  localparam int unsigned StartTimeoutDef = 16;

endpackage

// File: rtl/period_timer.sv
// Auto-refresh reload counter: ticks once every period_i cycles; period_i == 0 disables it.
module period_timer #(
  parameter int unsigned Width = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] period_i,
  output logic             tick_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    tick_o  = 1'b0;
    if (period_i == '0) begin
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (!armed_q) begin
      cnt_d   = period_i - One;
      armed_d = 1'b1;
    end else if (cnt_q == '0) begin
      // A new period value is only picked up here, at the reload.
      tick_o = 1'b1;
      cnt_d  = period_i - One;
    end else begin
      cnt_d = cnt_q - One;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame-level sequencer: waits for a request and a full frame of pixel data, fires the
// start pulse, watches string activity and enforces the latch gap before the next frame.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned FIFO_ADDR_WIDTH = 13,
  parameter int unsigned FRAME_WORDS     = FrameWordsDef,
  parameter int unsigned LATCH_CYCLES    = LatchCyclesDef,
  parameter int unsigned START_TIMEOUT   = StartTimeoutDef,
  parameter int unsigned PERIOD_WIDTH    = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FIFO_ADDR_WIDTH:0] fifo_full_count,
  input  logic                     trigger,
  input  logic [PERIOD_WIDTH-1:0]  frame_period,
  input  logic                     string_active,
  output logic                     h_blank_out,
  output logic                     busy,
  output logic [2:0]               state,
  output logic [15:0]              frame_count,
  output logic                     late_frame,
  output logic                     skipped_frame,
  output logic                     start_error
);

  localparam int unsigned ToW  = $clog2(START_TIMEOUT + 1);
  localparam int unsigned LatW = $clog2(LATCH_CYCLES + 1);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic              seen_q, seen_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              h_blank_q, h_blank_d;
  logic              busy_q, busy_d;
  logic              late_q, late_d;
  logic              skip_q, skip_d;
  logic              err_q, err_d;

  logic tick, req, consume, count_ok;

  period_timer #(
    .Width(PERIOD_WIDTH)
  ) u_period_timer (
    .clk_i   (clk),
    .rst_i   (reset),
    .period_i(frame_period),
    .tick_o  (tick)
  );

  assign count_ok = 32'(fifo_full_count) >= FRAME_WORDS;
  assign req      = trigger | tick;
  assign consume  = (state_q == StIdle) && pending_q;

  always_comb begin
    state_d       = state_q;
    seen_d        = seen_q;
    to_cnt_d      = to_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    frame_count_d = frame_count_q;
    err_d         = 1'b0;
    // A request landing on the consume cycle becomes the next pending one, not a skip.
    pending_d     = consume ? req : (pending_q | req);
    skip_d        = req & pending_q & ~consume;
    late_d        = tick & (state_q == StWaitData);

    case (state_q)
      StIdle: begin
        if (pending_q) state_d = StWaitData;
      end
      StWaitData: begin
        if (count_ok) state_d = StStart;
      end
      StStart: begin
        state_d  = StActive;
        seen_d   = 1'b0;
        // The start cycle itself counts toward the activity timeout.
        to_cnt_d = ToW'(1);
      end
      StActive: begin
        if (string_active) seen_d = 1'b1;
        if (!seen_q) to_cnt_d = to_cnt_q + ToW'(1);
        if (seen_q && !string_active) begin
          state_d       = StLatch;
          lat_cnt_d     = '0;
          frame_count_d = frame_count_q + 16'd1;
        end else if (!seen_q && !string_active && to_cnt_q >= ToW'(START_TIMEOUT - 1)) begin
          state_d   = StLatch;
          lat_cnt_d = '0;
          err_d     = 1'b1;
        end
      end
      StLatch: begin
        if (lat_cnt_q == LatW'(LATCH_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          lat_cnt_d = lat_cnt_q + LatW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    h_blank_d = (state_d == StStart);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pending_q     <= 1'b0;
      seen_q        <= 1'b0;
      to_cnt_q      <= '0;
      lat_cnt_q     <= '0;
      frame_count_q <= '0;
      h_blank_q     <= 1'b0;
      busy_q        <= 1'b0;
      late_q        <= 1'b0;
      skip_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      seen_q        <= seen_d;
      to_cnt_q      <= to_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      frame_count_q <= frame_count_d;
      h_blank_q     <= h_blank_d;
      busy_q        <= busy_d;
      late_q        <= late_d;
      skip_q        <= skip_d;
      err_q         <= err_d;
    end
  end

  assign h_blank_out   = h_blank_q;
  assign busy          = busy_q;
  assign state         = state_q;
  assign frame_count   = frame_count_q;
  assign late_frame    = late_q;
  assign skipped_frame = skip_q;
  assign start_error   = err_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: directed sequences, a data-threshold table and
// a randomized run against an edge-numbered reference model.
module tb_frame_scheduler;

  localparam int FW = 4248;
  localparam int LC = 6000;
  localparam int ST = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] fifo_full_count = '0;
  logic        trigger = 1'b0;
  logic [23:0] frame_period = '0;
  logic        string_active = 1'b0;
  logic        h_blank_out, busy, late_frame, skipped_frame, start_error;
  logic [2:0]  state;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_err = 0;
  int e = 0;

  int hb_n, hb_first, hb_last, late_n, late_first, skip_n, err_n, err_first;

  // reference model state
  int m_st, m_per, m_fc, m_start_e, m_latch_e;
  bit m_pend, m_seen, m_hb, m_busy, m_late, m_skip, m_err;

  typedef struct {
    logic [13:0] count;
    logic        start;
  } thr_vec_t;
  thr_vec_t tv[7];

  always #25 clk = ~clk;

  frame_scheduler #(
    .FIFO_ADDR_WIDTH(13),
    .FRAME_WORDS    (FW),
    .LATCH_CYCLES   (LC),
    .START_TIMEOUT  (ST),
    .PERIOD_WIDTH   (24)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_full_count(fifo_full_count),
    .trigger        (trigger),
    .frame_period   (frame_period),
    .string_active  (string_active),
    .h_blank_out    (h_blank_out),
    .busy           (busy),
    .state          (state),
    .frame_count    (frame_count),
    .late_frame     (late_frame),
    .skipped_frame  (skipped_frame),
    .start_error    (start_error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (edge %0d): got 0x%0h, expected 0x%0h", name, e, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    e = 0;
  endtask

  task automatic run_count(input int n);
    hb_n = 0; late_n = 0; skip_n = 0; err_n = 0;
    hb_first = -1; hb_last = -1; late_first = -1; err_first = -1;
    for (int i = 0; i < n; i++) begin
      step();
      if (h_blank_out) begin
        hb_n++;
        if (hb_first < 0) hb_first = e;
        hb_last = e;
      end
      if (late_frame) begin
        late_n++;
        if (late_first < 0) late_first = e;
      end
      if (skipped_frame) skip_n++;
      if (start_error) begin
        err_n++;
        if (err_first < 0) err_first = e;
      end
    end
  endtask

  // Behaviour at edge ed given the inputs sampled there; ticks fall at 1 + k*period.
  function automatic void model_step(input int ed, input bit tr, input bit sa, input int cnt);
    bit tick, req, consume;
    int nst;
    tick    = (m_per != 0) && (ed > 1) && ((ed - 1) % m_per == 0);
    req     = tr || tick;
    consume = (m_st == 0) && m_pend;
    m_skip  = req && m_pend && !consume;
    m_late  = tick && (m_st == 1);
    m_err   = 1'b0;
    nst     = m_st;
    case (m_st)
      0: if (m_pend) nst = 1;
      1: if (cnt >= FW) nst = 2;
      2: begin
        nst       = 3;
        m_seen    = 1'b0;
        m_start_e = ed - 1;
      end
      3: begin
        if (m_seen && !sa) begin
          nst       = 4;
          m_fc      = (m_fc + 1) % 65536;
          m_latch_e = ed;
        end else if (!m_seen && !sa && (ed - m_start_e >= ST)) begin
          nst       = 4;
          m_err     = 1'b1;
          m_latch_e = ed;
        end
        if (sa) m_seen = 1'b1;
      end
      4: if (ed - m_latch_e >= LC) nst = 0;
      default: nst = 0;
    endcase
    m_pend = consume ? req : (m_pend || req);
    m_st   = nst;
    m_hb   = (nst == 2);
    m_busy = (nst != 0);
  endfunction

  initial begin
    int p, rise, fall, en;
    logic [23:0] act_v, exp_v;

    tv[0] = '{count: 14'd4247,  start: 1'b0};
    tv[1] = '{count: 14'd0,     start: 1'b0};
    tv[2] = '{count: 14'd4248,  start: 1'b1};
    tv[3] = '{count: 14'd4249,  start: 1'b1};
    tv[4] = '{count: 14'd16383, start: 1'b1};
    tv[5] = '{count: 14'd4096,  start: 1'b0};
    tv[6] = '{count: 14'd8192,  start: 1'b1};

    // Trigger with data ready, then a normal frame
    fifo_full_count = 14'(FW);
    frame_period    = '0;
    do_reset();
    chk("reset outputs", {h_blank_out, busy, state, frame_count, late_frame, skipped_frame,
        start_error}, 24'h0);
    repeat (9) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("t1 state@N", state, 3'd0);
    step();
    chk("t1 state@N+1", state, 3'd1);
    chk("t1 hb@N+1", h_blank_out, 1'b0);
    step();
    chk("t1 hb@N+2", h_blank_out, 1'b1);
    chk("t1 state@N+2", state, 3'd2);
    chk("t1 busy", busy, 1'b1);
    step();
    chk("t1 hb@N+3", h_blank_out, 1'b0);
    chk("t1 state active", state, 3'd3);
    string_active = 1'b1;
    repeat (100) step();
    chk("t1 still active", state, 3'd3);
    string_active = 1'b0;
    step();
    chk("t1 latch entered", state, 3'd4);
    chk("t1 frame_count", frame_count, 16'd1);
    repeat (LC - 1) step();
    chk("t1 latch held", state, 3'd4);
    step();
    chk("t1 back idle", state, 3'd0);
    chk("t1 busy low", busy, 1'b0);

    // Data threshold table: start only once the count reaches a full frame
    for (int i = 0; i < 7; i++) begin
      fifo_full_count = tv[i].count;
      frame_period    = '0;
      do_reset();
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      step();
      step();
      chk($sformatf("thr hb count=%0d", tv[i].count), h_blank_out, tv[i].start);
      chk($sformatf("thr state count=%0d", tv[i].count), state, tv[i].start ? 3'd2 : 3'd1);
    end

    // Late frames while starved of data
    fifo_full_count = 14'(FW - 1);
    frame_period    = 24'd1000;
    do_reset();
    run_count(3100);
    chk("late count", late_n, 2);
    chk("late first edge", late_first, 2001);
    chk("late skip count", skip_n, 1);
    chk("late no start", hb_n, 0);
    chk("late waiting", state, 3'd1);
    fifo_full_count = 14'(FW);
    step();
    chk("threshold start hb", h_blank_out, 1'b1);
    chk("threshold start state", state, 3'd2);

    // Auto mode, then disabled
    fifo_full_count = 14'(FW);
    frame_period    = 24'd8000;
    do_reset();
    run_count(16100);
    chk("auto starts", hb_n, 2);
    chk("auto first start", hb_first, 8003);
    chk("auto spacing", hb_last - hb_first, 8000);
    frame_period = '0;
    run_count(9000);
    chk("auto disabled starts", hb_n, 0);

    // Coincident request, start timeout, overlapping requests in LATCH
    fifo_full_count = 14'(FW);
    frame_period    = 24'd500;
    do_reset();
    repeat (500) step();
    trigger = 1'b1;
    step();
    trigger      = 1'b0;
    frame_period = '0;
    chk("coinc skip", skipped_frame, 1'b0);
    run_count(18);
    chk("coinc one start", hb_n, 1);
    chk("coinc start edge", hb_first, 503);
    chk("coinc no skip", skip_n, 0);
    chk("timeout pulses", err_n, 1);
    chk("timeout edge", err_first, 519);
    chk("timeout latch", state, 3'd4);
    chk("timeout frame_count", frame_count, 16'd0);
    step();
    chk("timeout pulse width", start_error, 1'b0);
    repeat (79) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("latch req1 skip", skipped_frame, 1'b0);
    repeat (99) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("latch req2 skip", skipped_frame, 1'b1);
    run_count(5900);
    chk("latch further frames", hb_n, 1);
    chk("latch further start edge", hb_first, 6521);
    chk("latch no more skips", skip_n, 0);

    // Reset during the start pulse, then a normal frame
    fifo_full_count = 14'(FW);
    frame_period    = '0;
    do_reset();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    step();
    chk("rst pre hb", h_blank_out, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst async outputs", {h_blank_out, busy, state, frame_count, late_frame, skipped_frame,
        start_error}, 24'h0);
    do_reset();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    step();
    chk("rst again hb", h_blank_out, 1'b1);
    step();
    string_active = 1'b1;
    repeat (5) step();
    string_active = 1'b0;
    step();
    chk("rst frame latch", state, 3'd4);
    chk("rst frame_count", frame_count, 16'd1);

    // Randomized run against the reference model
    p               = $urandom_range(1500, 2500);
    frame_period    = 24'(p);
    trigger         = 1'b0;
    string_active   = 1'b0;
    fifo_full_count = 14'(FW);
    do_reset();
    m_st = 0; m_per = p; m_fc = 0; m_start_e = 0; m_latch_e = 0;
    m_pend = 0; m_seen = 0; m_hb = 0; m_busy = 0; m_late = 0; m_skip = 0; m_err = 0;
    rise = 0;
    fall = 0;
    for (int i = 0; i < 20000; i++) begin
      en              = e + 1;
      trigger         = ($urandom_range(0, 299) == 0);
      fifo_full_count = 14'($urandom_range(FW - 8, FW + 8));
      string_active   = (en >= rise) && (en < fall);
      step();
      model_step(e, trigger, string_active, int'(fifo_full_count));
      act_v = {h_blank_out, busy, state, frame_count, late_frame, skipped_frame, start_error};
      exp_v = {m_hb, m_busy, 3'(m_st), 16'(m_fc), m_late, m_skip, m_err};
      chk("random outputs", act_v, exp_v);
      if (m_hb) begin
        if ($urandom_range(0, 3) == 0) begin
          rise = 0;
          fall = 0;
        end else begin
          rise = e + 1 + $urandom_range(0, 18);
          fall = rise + $urandom_range(1, 30);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
